seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 31 +++
 rtl/seven_seg_scanner_bin2bcd_seq.sv | 54 +++++
 rtl/seven_seg_scanner.sv | 51 +++++
 tb/tb_seven_seg_scanner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg: segment codes, converter FSM states and digit-to-segment helper.
package seven_seg_scanner_pkg;
  typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} state_e;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scanner_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, LOAD -> 16x SHIFT -> COMMIT (18-cycle period).
module bin2bcd_seq
  import seven_seg_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bin_i,
  output logic [15:0] bcd_o,
  output logic        over_o
);
  state_e      state_q;
  logic [15:0] bin_q, scratch_q, adj, bcd_q;
  logic [3:0]  cnt_q;
  logic        over_pend_q, over_q;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3 : scratch_q[4*i +: 4];
  end
  // Only COMMIT touches bcd_q/over_q, so partial scratch values never leave this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      over_pend_q <= 1'b0;
      bcd_q       <= '0;
      over_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          bin_q       <= bin_i;
          scratch_q   <= '0;
          cnt_q       <= '0;
          over_pend_q <= bin_i > 16'd9999;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          scratch_q <= {adj[14:0], bin_q[15]};
          bin_q     <= {bin_q[14:0], 1'b0};
          cnt_q     <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= COMMIT;
        end
        COMMIT: begin
          bcd_q   <= scratch_q;
          over_q  <= over_pend_q;
          state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end
  assign bcd_o  = bcd_q;
  assign over_o = over_q;
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed 7-segment driver with sequential BCD conversion.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the upper three slots.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display_number,
  output logic [3:0]  digit,
  output logic [7:0]  seven_seg
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    digit_q;
  logic [7:0]    seg_q, seg_d;
  logic [15:0]   bcd;
  logic          over, wrap, lead;
  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .bin_i  (display_number),
    .bcd_o  (bcd),
    .over_o (over)
  );
  assign wrap = cnt_q == CW'(REFRESH_DIV - 1);
`ifdef LEADING_ZERO_BLANK_EN
  assign lead = (idx_q != 2'd0) && ((bcd >> {idx_q, 2'b00}) == 16'd0);
`else
  assign lead = 1'b0;
`endif
  assign seg_d = over ? SEG_DASH : lead ? SEG_BLANK : seg_code(bcd[4*idx_q +: 4]);
  // digit and segments are both decoded from idx_q on the same edge, keeping them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      digit_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + CW'(1);
      if (wrap) idx_q <= idx_q + 2'd1;
      digit_q <= ~(4'b0001 << idx_q);
      seg_q   <= seg_d;
    end
  end
  assign digit     = digit_q;
  assign seven_seg = seg_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized self-checking bench with an arithmetic display model.
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] display_number = 16'd0;
  logic [3:0]  digit;
  logic [7:0]  seven_seg;
  int n_checks = 0;
  int n_fail = 0;
  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .display_number (display_number),
    .digit          (digit),
    .seven_seg      (seven_seg)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_seg(input int n, input int slot);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int pw [4] = '{1, 10, 100, 1000};
    if (n > 9999) return 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && n < pw[slot]) return 8'hFF;
`endif
    return tbl[(n / pw[slot]) % 10];
  endfunction
  function automatic int slot_of(input logic [3:0] d);
    case (d)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    display_number = 16'd0;
    repeat (3) tick();
    n_checks++;
    if (digit !== 4'b1111 || seven_seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_hold: digit=%b seg=%h, required 1111/ff", digit, seven_seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (digit !== 4'b1110 || seven_seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL first_edge: digit=%b seg=%h, required 1110/c0", digit, seven_seg);
    end
  endtask
  task automatic test_scan();
    logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 2; k <= 16; k++) begin
      int s;
      tick();
      s = ((k - 1) / 4) % 4;
      n_checks++;
      if (digit !== pat[s] || seven_seg !== exp_seg(0, s)) begin
        n_fail++;
        $display("FAIL scan k=%0d: digit=%b seg=%h, required %b/%h", k, digit, seven_seg, pat[s], exp_seg(0, s));
      end
    end
  endtask
  task automatic check_shown(input int n, input string tag);
    for (int k = 0; k < 16; k++) begin
      int s;
      tick();
      s = slot_of(digit);
      n_checks++;
      if (s < 0) begin
        n_fail++;
        $display("FAIL %s digit: digit=%b, required one-hot-low", tag, digit);
      end else if (seven_seg !== exp_seg(n, s)) begin
        n_fail++;
        $display("FAIL %s value=%0d slot=%0d: seg=%h, required %h", tag, n, s, seven_seg, exp_seg(n, s));
      end
    end
  endtask
  task automatic test_value(input int n, input string tag);
    display_number = 16'(n);
    repeat (38) tick();
    check_shown(n, tag);
  endtask
  task automatic test_reset_mid();
    test_value(0, "pre_reset");
    display_number = 16'd5678;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (digit !== 4'b1111 || seven_seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_reset: digit=%b seg=%h, required 1111/ff", digit, seven_seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      int s;
      tick();
      s = slot_of(digit);
      n_checks++;
      if (s < 0 || seven_seg !== exp_seg(0, s)) begin
        n_fail++;
        $display("FAIL post_reset_zero k=%0d: digit=%b seg=%h, required zero display", k, digit, seven_seg);
      end
    end
    repeat (20) tick();
    check_shown(5678, "after_reset");
  endtask
  task automatic test_random();
    int hist [$];
    hist.push_back(int'(display_number));
    for (int c = 0; c < 30; c++) begin
      int v = int'($urandom_range(0, 10499));
      int hold = int'($urandom_range(1, 40));
      display_number = 16'(v);
      hist.push_back(v);
      for (int t = 0; t < hold; t++) begin
        int s;
        bit ok = 1'b0;
        tick();
        s = slot_of(digit);
        if (s >= 0) foreach (hist[i]) if (exp_seg(hist[i], s) === seven_seg) ok = 1'b1;
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL random_seg: digit=%b seg=%h, required code of a sampled value", digit, seven_seg);
        end
      end
    end
    test_value(int'($urandom_range(0, 9999)), "random_final");
  endtask
  initial begin
    test_reset();
    test_scan();
    test_value(1234, "v1234");
    test_value(9999, "v9999");
    test_value(0, "v0");
    test_value(10000, "overrange");
    test_value(42, "v42");
    test_value(65535, "max_in");
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
